dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_array.sv | 31 +++
 rtl/dmem_responder.sv | 131 +++++++++++++
 tb/tb_dmem_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, defaults,
// wait-counter width and the address legality check.
package dmem_pkg;

  localparam int unsigned DEPTH_WORDS_DEF = 256;
  localparam int unsigned WAIT_CYCLES_DEF = 2;
  localparam int unsigned CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Misaligned or beyond the last stored word.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-organised word storage: synchronous write, combinational big-endian read.
// Contents are deliberately never reset.
import dmem_pkg::*;

module dmem_array #(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [7:0] mem [DEPTH_WORDS*4];

  // Lowest byte address holds the most significant byte.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[{idx, 2'b00}] <= wdata[31:24];
      mem[{idx, 2'b01}] <= wdata[23:16];
      mem[{idx, 2'b10}] <= wdata[15:8];
      mem[{idx, 2'b11}] <= wdata[7:0];
    end
  end

  assign rdata = {mem[{idx, 2'b00}], mem[{idx, 2'b01}],
                  mem[{idx, 2'b10}], mem[{idx, 2'b11}]};

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with a fixed number of wait states,
// address error detection and a held response under backpressure.
import dmem_pkg::*;

module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, write_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic        idle;
  logic        accept;
  logic        enter_resp;
  logic        op_write;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic        op_err;
  logic        arr_we;
  logic [31:0] arr_rdata;

  assign idle   = (state_q == IDLE);
  assign accept = idle && req_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // req_ready is also masked by rst so it reads 0 while reset is held.
  always_comb begin
    req_ready  = rst && idle;
    stall      = !idle;
    resp_valid = (state_q == RESP);
  end

  // With zero wait states RESP is entered on the accept edge itself, before the
  // request is latched, so the operation is taken straight from the ports.
  assign enter_resp = (state_d == RESP) && (state_q != RESP);
  assign op_write   = idle ? req_write : write_q;
  assign op_addr    = idle ? req_addr  : addr_q;
  assign op_wdata   = idle ? req_wdata : wdata_q;
  assign op_err     = addr_err(op_addr, DEPTH_WORDS);
  assign arr_we     = enter_resp && op_write && !op_err;

  always_comb begin
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      cnt_d   = CNT_LOAD;
      write_d = req_write;
      addr_d  = req_addr;
      wdata_d = req_wdata;
    end else if ((state_q == WAIT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (enter_resp) begin
      err_d   = op_err;
      rdata_d = (op_err || op_write) ? 32'h0 : arr_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    write_q <= write_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .idx   (op_addr[IDX_W+1:2]),
    .wdata (op_wdata),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYCLES=2 instance against a timestamp/
// associative-memory model, plus a WAIT_CYCLES=0 instance under streaming load.
module tb_dmem_responder;

  localparam int W     = 2;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err, stall;
  logic [31:0] resp_rdata;

  logic        rst0 = 1'b0;
  logic        req_valid0, req_ready0, req_write0;
  logic [31:0] req_addr0, req_wdata0;
  logic        resp_valid0, resp_ready0, resp_err0, stall0;
  logic [31:0] resp_rdata0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .stall(stall)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_write(req_write0), .req_addr(req_addr0), .req_wdata(req_wdata0),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0), .resp_rdata(resp_rdata0),
    .resp_err(resp_err0), .stall(stall0)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the W=2 instance ----------------
  int          cyc = 0;
  bit          m_busy = 1'b0;
  int          m_acc;
  bit          m_wr, m_err, m_rknown;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [31:0] mem_m [int];

  function automatic bit mod_err(input logic [31:0] a);
    return ((a % 4) != 0) || ((a / 4) >= DEPTH);
  endfunction

  always @(negedge rst) m_busy = 1'b0;

  always @(posedge clk) begin
    bit vis;
    vis = m_busy && (cyc >= m_acc + W);
    cyc++;
    if (rst) begin
      if (m_busy) begin
        if (vis && resp_ready) m_busy = 1'b0;
      end else if (req_valid) begin
        m_busy = 1'b1; m_acc = cyc; m_wr = req_write;
        m_addr = req_addr; m_wdata = req_wdata; m_err = mod_err(req_addr);
      end
      if (m_busy && (cyc == m_acc + W)) begin
        if (m_err) begin
          m_rdata = 32'h0; m_rknown = 1'b1;
        end else if (m_wr) begin
          mem_m[int'(m_addr / 4)] = m_wdata; m_rdata = 32'h0; m_rknown = 1'b1;
        end else begin
          m_rknown = mem_m.exists(int'(m_addr / 4));
          m_rdata  = m_rknown ? mem_m[int'(m_addr / 4)] : 32'h0;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit exp_vis;
    exp_vis = rst && m_busy && (cyc >= m_acc + W);
    check32("req_ready", {31'b0, req_ready}, {31'b0, rst && !m_busy});
    check32("stall", {31'b0, stall}, {31'b0, rst && m_busy});
    check32("resp_valid", {31'b0, resp_valid}, {31'b0, exp_vis});
    if (!rst) begin
      check32("rst_rdata", resp_rdata, 32'h0);
      check32("rst_err", {31'b0, resp_err}, 32'h0);
    end else if (exp_vis) begin
      check32("resp_err", {31'b0, resp_err}, {31'b0, m_err});
      if (m_rknown) check32("resp_rdata", resp_rdata, m_rdata);
    end
  end

  // ---------------- directed helpers for the W=2 instance ----------------
  task automatic accept_only(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                             output int acc);
    bit got = 1'b0;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = data;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); got = req_ready;
      @(posedge clk); #1;
    end
    if (!got) check32("accept_timeout", 32'h0, 32'h1);
    acc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                     input int hold, output logic [31:0] rd, output bit er, output int lat);
    int acc;
    bit found = 1'b0;
    resp_ready = (hold == 0);
    accept_only(wr, addr, data, acc);
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk); found = resp_valid;
    end
    if (!found) check32("resp_timeout", 32'h0, 32'h1);
    lat = cyc + 1 - acc;
    rd = resp_rdata; er = resp_err;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      req_valid = (k == 2);
      @(negedge clk);
      check32("hold_valid", {31'b0, resp_valid}, 32'h1);
      check32("hold_rdata", resp_rdata, rd);
      check32("hold_err", {31'b0, resp_err}, {31'b0, er});
      check32("hold_ready", {31'b0, req_ready}, 32'h0);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- WAIT_CYCLES=0 streaming phase ----------------
  logic [31:0] wd0 [32];
  int k0, nresp0;

  task automatic drive0(input int k);
    req_write0 = ((k % 2) == 0);
    req_addr0  = 32'((k / 2) * 4);
    req_wdata0 = wd0[(k / 2) % 32];
  endtask

  initial begin
    logic [31:0] rd;
    bit er, rdy;
    int lat, acc;
    bit found;

    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; resp_ready = 1;
    req_valid0 = 0; req_write0 = 0; req_addr0 = 0; req_wdata0 = 0; resp_ready0 = 1;
    foreach (wd0[i]) wd0[i] = $urandom;

    repeat (3) @(posedge clk);
    #1 rst0 = 1'b1;
    k0 = 0; nresp0 = 0; drive0(0); req_valid0 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bit exp_v;
      @(negedge clk);
      exp_v = ((i % 2) == 1);
      check32("w0_resp_valid", {31'b0, resp_valid0}, {31'b0, exp_v});
      check32("w0_stall", {31'b0, stall0}, {31'b0, exp_v});
      check32("w0_req_ready", {31'b0, req_ready0}, {31'b0, !exp_v});
      if (resp_valid0) begin
        int j;
        nresp0++;
        j = k0 - 1;
        if ((j % 2) == 1) check32("w0_load_data", resp_rdata0, wd0[(j / 2) % 32]);
        else              check32("w0_store_rdata", resp_rdata0, 32'h0);
        check32("w0_err", {31'b0, resp_err0}, 32'h0);
      end
      rdy = req_ready0;
      @(posedge clk); #1;
      if (rdy) begin k0++; drive0(k0); end
    end
    req_valid0 = 1'b0;
    check32("w0_resp_count", nresp0, 32'd20);

    @(negedge clk);
    check32("reset_req_ready", {31'b0, req_ready}, 32'h0);
    check32("reset_resp_valid", {31'b0, resp_valid}, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check32("ready_after_reset", {31'b0, req_ready}, 32'h1);
    @(posedge clk); #1;

    txn(1'b1, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
    check32("st10_err", {31'b0, er}, 32'h0);
    check32("st10_rdata", rd, 32'h0);
    check32("st10_latency", lat, 32'd3);
    txn(1'b0, 32'h10, 32'h0, 0, rd, er, lat);
    check32("ld10_rdata", rd, 32'hDEADBEEF);
    check32("ld10_err", {31'b0, er}, 32'h0);
    check32("ld10_latency", lat, 32'd3);

    txn(1'b1, 32'h20, 32'h11223344, 0, rd, er, lat);
    check32("byte20", {24'b0, dut.u_array.mem[32]}, 32'h11);
    check32("byte23", {24'b0, dut.u_array.mem[35]}, 32'h44);
    txn(1'b1, 32'h22, 32'h55667788, 0, rd, er, lat);
    check32("mis22_err", {31'b0, er}, 32'h1);
    check32("mis22_rdata", rd, 32'h0);
    txn(1'b0, 32'h20, 32'h0, 0, rd, er, lat);
    check32("ld20_unchanged", rd, 32'h11223344);
    txn(1'b1, 32'h400, 32'h99999999, 0, rd, er, lat);
    check32("oor400_err", {31'b0, er}, 32'h1);
    txn(1'b1, 32'h3FC, 32'h0BADCAFE, 0, rd, er, lat);
    check32("last_word_err", {31'b0, er}, 32'h0);
    txn(1'b0, 32'h3FC, 32'h0, 0, rd, er, lat);
    check32("last_word_rdata", rd, 32'h0BADCAFE);

    txn(1'b0, 32'h10, 32'h0, 5, rd, er, lat);
    check32("bp_rdata", rd, 32'hDEADBEEF);

    txn(1'b1, 32'h30, 32'h12345678, 0, rd, er, lat);
    accept_only(1'b1, 32'h30, 32'hCAFEF00D, acc);
    @(posedge clk); #1 rst = 1'b0;
    #1;
    check32("rstwait_ready", {31'b0, req_ready}, 32'h0);
    check32("rstwait_stall", {31'b0, stall}, 32'h0);
    check32("rstwait_valid", {31'b0, resp_valid}, 32'h0);
    check32("rstwait_rdata", resp_rdata, 32'h0);
    check32("rstwait_err", {31'b0, resp_err}, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    txn(1'b0, 32'h30, 32'h0, 0, rd, er, lat);
    check32("ld30_old", rd, 32'h12345678);
    n_assert++;
    if (rd === 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL ld30_aborted: got %h, required anything but cafef00d", rd);
    end

    resp_ready = 1'b0;
    accept_only(1'b1, 32'h34, 32'hA5A55A5A, acc);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); found = resp_valid;
    end
    if (!found) check32("rstresp_timeout", 32'h0, 32'h1);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1; resp_ready = 1'b1;
    txn(1'b0, 32'h34, 32'h0, 0, rd, er, lat);
    check32("ld34_kept", rd, 32'hA5A55A5A);

    for (int c = 0; c < 1500; c++) begin
      int r;
      @(posedge clk); #1;
      if (!rst) rst = 1'b1;
      else if (($urandom % 250) == 0) rst = 1'b0;
      req_valid  = (($urandom % 3) != 0);
      req_write  = $urandom % 2;
      r = $urandom % 16;
      if (r < 12)      req_addr = ($urandom % 8) * 4 + 32'h10;
      else if (r < 14) req_addr = $urandom % 1024;
      else             req_addr = 32'h400 + ($urandom % 64) * 4;
      req_wdata  = $urandom;
      resp_ready = (($urandom % 4) != 0);
    end
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
    repeat (10) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
